// File: rtl/pred_hist_pkg.sv
// Shared types, defaults and byte-layout helpers for the prediction history buffer.
package pred_hist_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StRdReq,
        StDig,
        StScr,
        StDone
    } dump_state_e;

    localparam int unsigned DIGIT_W_DEF = 4;
    localparam int unsigned SCORE_W_DEF = 16;
    localparam int unsigned ENTRY_W     = DIGIT_W_DEF + SCORE_W_DEF;
    localparam int unsigned SCORE_BYTES = SCORE_W_DEF / 8;

    // Header byte: fill count in the low bits, upper bits zero.
    localparam logic [7:0] HDR_ZERO = 8'h00;

    function automatic int unsigned entry_w(input int unsigned digit_w,
                                            input int unsigned score_w);
        return digit_w + score_w;
    endfunction

    function automatic int unsigned score_bytes(input int unsigned score_w);
        return score_w / 8;
    endfunction

    function automatic logic [7:0] hdr_byte(input int unsigned fill_cnt);
        return HDR_ZERO | 8'(fill_cnt);
    endfunction

endpackage

// File: rtl/pred_hist_mem.sv
// Simple dual-port RAM: one write port, one synchronous read port with read enable.
module pred_hist_mem
    import pred_hist_pkg::*;
#(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = ENTRY_W,
    localparam int unsigned Aw   = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [Aw-1:0]    waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             re_i,
    input  logic [Aw-1:0]    raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/prediction_history_buffer.sv
// Ring buffer of recent classifier results with random read by age and a
// byte-serial valid/ready dump of the whole history.
module prediction_history_buffer
    import pred_hist_pkg::*;
#(
    parameter int unsigned DIGIT_W = DIGIT_W_DEF,
    parameter int unsigned SCORE_W = SCORE_BYTES * 8,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DIGIT_W-1:0]       wr_digit,
    input  logic [SCORE_W-1:0]       wr_score,
    input  logic [$clog2(DEPTH)-1:0] rd_age,
    output logic [DIGIT_W-1:0]       rd_digit,
    output logic [SCORE_W-1:0]       rd_score,
    output logic                     rd_hit,
    output logic [DIGIT_W-1:0]       latest_digit,
    output logic [$clog2(DEPTH):0]   fill,
    output logic [CNT_W-1:0]         total_count,
    input  logic                     dump_start,
    output logic [7:0]               dump_data,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic                     dump_last,
    output logic                     dump_busy,
    output logic                     drop_flag
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = AW + 1;
    localparam int unsigned EW = entry_w(DIGIT_W, SCORE_W);
    localparam int unsigned SB = score_bytes(SCORE_W);
    localparam int unsigned BW = (SB > 1) ? $clog2(SB) : 1;

    localparam logic [FW-1:0] FILL_MAX  = FW'(DEPTH);
    localparam logic [BW-1:0] BYTE_LAST = BW'(SB - 1);

    dump_state_e state_q, state_d;

    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic [CNT_W-1:0]   total_q, total_d;
    logic [DIGIT_W-1:0] latest_q, latest_d;
    logic               pend_vld_q, pend_vld_d;
    logic [EW-1:0]      pend_q, pend_d;
    logic               drop_q, drop_d;
    logic [AW-1:0]      ptr_snap_q, ptr_snap_d;
    logic [FW-1:0]      fill_snap_q, fill_snap_d;
    logic [FW-1:0]      k_q, k_d;
    logic [BW-1:0]      bcnt_q, bcnt_d;
    logic               rd_hit_q, rd_hit_d;
    logic               rd_src_q, rd_src_d;
    logic [EW-1:0]      rd_hold_q, rd_hold_d;

    logic               mem_we;
    logic [AW-1:0]      mem_waddr;
    logic [EW-1:0]      mem_wdata;
    logic               mem_re;
    logic [AW-1:0]      mem_raddr;
    logic [EW-1:0]      mem_rdata;

    logic               busy;
    logic               xfer;
    logic [EW-1:0]      wr_entry;
    logic [EW-1:0]      rd_entry;
    logic [SCORE_W-1:0] cur_score;

    assign busy      = (state_q != StIdle);
    assign xfer      = dump_valid && dump_ready;
    assign wr_entry  = {wr_digit, wr_score};
    assign cur_score = mem_rdata[SCORE_W-1:0];

    // The RAM output register is shared with the dump path, so the random-read
    // result is only taken from it on the cycle after an rd_age read.
    assign rd_entry  = rd_src_q ? mem_rdata : rd_hold_q;

    pred_hist_mem #(
        .Depth (DEPTH),
        .Width (EW)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .re_i    (mem_re),
        .raddr_i (mem_raddr),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        total_d     = total_q;
        latest_d    = latest_q;
        pend_vld_d  = pend_vld_q;
        pend_d      = pend_q;
        drop_d      = drop_q;
        ptr_snap_d  = ptr_snap_q;
        fill_snap_d = fill_snap_q;
        k_d         = k_q;
        bcnt_d      = bcnt_q;
        rd_hit_d    = 1'b0;
        rd_src_d    = 1'b0;
        rd_hold_d   = rd_entry;
        mem_we      = 1'b0;
        mem_waddr   = wr_ptr_q;
        mem_wdata   = wr_entry;
        mem_re      = 1'b0;
        mem_raddr   = wr_ptr_q - AW'(1) - rd_age;

        // Result accounting happens on every accepted pulse, busy or not.
        if (wr_en) begin
            latest_d = wr_digit;
            if (total_q != '1) begin
                total_d = total_q + 1'b1;
            end
        end

        if (!busy) begin
            if (pend_vld_q) begin
                // Held-over result commits first; a coincident write takes its place.
                mem_we    = 1'b1;
                mem_wdata = pend_q;
                if (wr_en) begin
                    pend_d = wr_entry;
                end else begin
                    pend_vld_d = 1'b0;
                end
            end else if (wr_en) begin
                mem_we = 1'b1;
            end
            if (mem_we) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + 1'b1;
                end
            end
        end else if (wr_en) begin
            pend_d     = wr_entry;
            pend_vld_d = 1'b1;
            if (pend_vld_q) begin
                drop_d = 1'b1;
            end
        end

        if (!busy && ({1'b0, rd_age} < fill_q)) begin
            rd_hit_d = 1'b1;
            rd_src_d = 1'b1;
            mem_re   = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (dump_start) begin
                    state_d     = StHdr;
                    ptr_snap_d  = wr_ptr_d;
                    fill_snap_d = fill_d;
                    drop_d      = 1'b0;
                    k_d         = '0;
                    bcnt_d      = '0;
                end
            end
            StHdr: begin
                if (xfer) begin
                    state_d = (fill_snap_q == '0) ? StDone : StRdReq;
                end
            end
            StRdReq: begin
                mem_re    = 1'b1;
                mem_raddr = ptr_snap_q - AW'(fill_snap_q) + AW'(k_q);
                state_d   = StDig;
            end
            StDig: begin
                if (xfer) begin
                    state_d = StScr;
                    bcnt_d  = '0;
                end
            end
            StScr: begin
                if (xfer) begin
                    if (bcnt_q == BYTE_LAST) begin
                        bcnt_d  = '0;
                        k_d     = k_q + 1'b1;
                        state_d = ((k_q + 1'b1) < fill_snap_q) ? StRdReq : StDone;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        dump_data = 8'h00;
        dump_last = 1'b0;
        unique case (state_q)
            StHdr: begin
                dump_data = hdr_byte(32'(fill_snap_q));
                dump_last = (fill_snap_q == '0);
            end
            StDig: begin
                dump_data = 8'(mem_rdata[EW-1 -: DIGIT_W]);
            end
            StScr: begin
                // MSB-first byte select within the score.
                dump_data = 8'(cur_score >> (8 * (SB - 1 - int'(bcnt_q))));
                dump_last = (bcnt_q == BYTE_LAST) && ((k_q + 1'b1) == fill_snap_q);
            end
            default: begin
                dump_data = 8'h00;
                dump_last = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            total_q     <= '0;
            latest_q    <= '0;
            pend_vld_q  <= 1'b0;
            pend_q      <= '0;
            drop_q      <= 1'b0;
            ptr_snap_q  <= '0;
            fill_snap_q <= '0;
            k_q         <= '0;
            bcnt_q      <= '0;
            rd_hit_q    <= 1'b0;
            rd_src_q    <= 1'b0;
            rd_hold_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            total_q     <= total_d;
            latest_q    <= latest_d;
            pend_vld_q  <= pend_vld_d;
            pend_q      <= pend_d;
            drop_q      <= drop_d;
            ptr_snap_q  <= ptr_snap_d;
            fill_snap_q <= fill_snap_d;
            k_q         <= k_d;
            bcnt_q      <= bcnt_d;
            rd_hit_q    <= rd_hit_d;
            rd_src_q    <= rd_src_d;
            rd_hold_q   <= rd_hold_d;
        end
    end

    assign rd_digit     = rd_entry[EW-1 -: DIGIT_W];
    assign rd_score     = rd_entry[SCORE_W-1:0];
    assign rd_hit       = rd_hit_q;
    assign latest_digit = latest_q;
    assign fill         = fill_q;
    assign total_count  = total_q;
    assign dump_valid   = (state_q == StHdr) || (state_q == StDig) || (state_q == StScr);
    assign dump_busy    = busy;
    assign drop_flag    = drop_q;

endmodule

// File: tb/tb_prediction_history_buffer.sv
// Self-checking bench: directed and random stimulus against a queue-based history model.
module tb_prediction_history_buffer;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SCORE_W = 16;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CNT_W   = 16;

    typedef logic [7:0] bq_t [$];

    logic               clk = 1'b0;
    logic               rst_n;
    logic               wr_en;
    logic [DIGIT_W-1:0] wr_digit;
    logic [SCORE_W-1:0] wr_score;
    logic [1:0]         rd_age;
    logic [DIGIT_W-1:0] rd_digit;
    logic [SCORE_W-1:0] rd_score;
    logic               rd_hit;
    logic [DIGIT_W-1:0] latest_digit;
    logic [2:0]         fill;
    logic [CNT_W-1:0]   total_count;
    logic               dump_start;
    logic [7:0]         dump_data;
    logic               dump_valid;
    logic               dump_ready;
    logic               dump_last;
    logic               dump_busy;
    logic               drop_flag;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: oldest entry at index 0, newest at the back.
    logic [19:0] ring [$];
    int unsigned m_total;
    logic [3:0]  m_latest;

    prediction_history_buffer #(
        .DIGIT_W (DIGIT_W),
        .SCORE_W (SCORE_W),
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_digit     (wr_digit),
        .wr_score     (wr_score),
        .rd_age       (rd_age),
        .rd_digit     (rd_digit),
        .rd_score     (rd_score),
        .rd_hit       (rd_hit),
        .latest_digit (latest_digit),
        .fill         (fill),
        .total_count  (total_count),
        .dump_start   (dump_start),
        .dump_data    (dump_data),
        .dump_valid   (dump_valid),
        .dump_ready   (dump_ready),
        .dump_last    (dump_last),
        .dump_busy    (dump_busy),
        .drop_flag    (drop_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic m_push(input logic [3:0] d, input logic [15:0] s);
        ring.push_back({d, s});
        if (ring.size() > DEPTH) void'(ring.pop_front());
    endtask

    function automatic bq_t build_dump();
        bq_t q;
        q.push_back(8'(ring.size()));
        foreach (ring[i]) begin
            q.push_back(8'(ring[i][19:16]));
            q.push_back(ring[i][15:8]);
            q.push_back(ring[i][7:0]);
        end
        return q;
    endfunction

    task automatic chk_state(input string tag);
        chk({tag, "_latest"}, 32'(latest_digit), 32'(m_latest));
        chk({tag, "_fill"}, 32'(fill), ring.size());
        chk({tag, "_total"}, 32'(total_count), m_total);
    endtask

    task automatic do_write(input logic [3:0] d, input logic [15:0] s);
        wr_en    = 1'b1;
        wr_digit = d;
        wr_score = s;
        @(negedge clk);
        wr_en = 1'b0;
        m_push(d, s);
        if (m_total < 65535) m_total++;
        m_latest = d;
    endtask

    task automatic do_read(input int age);
        logic [19:0] e;
        bit          hit;
        rd_age = 2'(age);
        @(negedge clk);
        hit = (age < ring.size());
        chk("rd_hit", 32'(rd_hit), 32'(hit));
        if (hit) begin
            e = ring[ring.size() - 1 - age];
            chk("rd_digit", 32'(rd_digit), 32'(e[19:16]));
            chk("rd_score", 32'(rd_score), 32'(e[15:0]));
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        ring.delete();
        m_total  = 0;
        m_latest = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // mode 0: always ready, 1: ready one cycle in three, 2: random ready.
    task automatic run_dump(input int mode, input bq_t exp, input int wr0, input int wr1);
        int          idx = 0;
        int          cyc = 0;
        bit          stall = 1'b0;
        logic [8:0]  held = '0;
        logic        rdy;
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        chk("drop_clr", 32'(drop_flag), 32'd0);
        while (idx < exp.size() && cyc < 300) begin
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 2) : 1'($urandom_range(0, 1));
            dump_ready = rdy;
            wr_en      = (cyc == wr0) || (cyc == wr1);
            wr_digit   = (cyc == wr0) ? 4'd6 : 4'd8;
            wr_score   = (cyc == wr0) ? 16'h0606 : 16'h0808;
            if (stall) chk("hold_stable", 32'({dump_last, dump_data}), 32'(held));
            if (dump_valid && rdy) begin
                chk("dump_byte", 32'(dump_data), 32'(exp[idx]));
                chk("dump_last", 32'(dump_last), 32'(idx == exp.size() - 1));
                idx++;
                stall = 1'b0;
            end else if (dump_valid) begin
                stall = 1'b1;
                held  = {dump_last, dump_data};
            end else begin
                stall = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        wr_en      = 1'b0;
        dump_ready = 1'b0;
        chk("dump_len", idx, exp.size());
        for (int i = 0; i < 10 && dump_busy; i++) @(negedge clk);
        chk("busy_drop", 32'(dump_busy), 32'd0);
    endtask

    initial begin
        bq_t exp_q;
        rst_n      = 1'b0;
        wr_en      = 1'b0;
        wr_digit   = '0;
        wr_score   = '0;
        rd_age     = '0;
        dump_start = 1'b0;
        dump_ready = 1'b0;
        m_total    = 0;
        m_latest   = '0;
        @(negedge clk);
        chk("rst_fill", 32'(fill), 32'd0);
        chk("rst_total", 32'(total_count), 32'd0);
        chk("rst_valid", 32'(dump_valid), 32'd0);
        chk("rst_rd", 32'({rd_hit, rd_digit, rd_score}), 32'd0);
        apply_reset();

        // Single write and read by age.
        do_write(4'd3, 16'h1234);
        chk_state("w1");
        do_read(0);
        do_read(1);
        chk("rd_hold", 32'({rd_digit, rd_score}), 32'h31234);

        // Wrap: five more writes overwrite the oldest.
        apply_reset();
        for (int d = 1; d <= 5; d++) do_write(4'(d), 16'(16'h1000 + d));
        chk_state("wrap");
        for (int a = 0; a < 4; a++) do_read(a);

        // Two-entry dump, streaming then throttled.
        apply_reset();
        do_write(4'd7, 16'h00AA);
        do_write(4'd9, 16'hBEEF);
        exp_q = build_dump();
        run_dump(0, exp_q, -1, -1);
        run_dump(1, exp_q, -1, -1);

        // Writes during a dump: second overwrites pending and sets drop.
        run_dump(0, exp_q, 1, 3);
        @(negedge clk);
        m_push(4'd8, 16'h0808);
        m_total += 2;
        m_latest = 4'd8;
        chk("drop_set", 32'(drop_flag), 32'd1);
        chk_state("pend");
        do_read(0);
        run_dump(0, build_dump(), -1, -1);

        // Random writes/reads against the model, then a random-ready dump.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                do_write(4'($urandom_range(0, 9)), 16'($urandom));
            end else begin
                do_read(int'($urandom_range(0, 3)));
            end
        end
        chk_state("rand");
        run_dump(2, build_dump(), -1, -1);

        // Reset in the middle of a score byte.
        do_write(4'd2, 16'h0102);
        do_write(4'd5, 16'hA5A5);
        dump_ready = 1'b1;
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_valid", 32'(dump_valid), 32'd1);
        chk("pre_rst_data", 32'(dump_data), 32'(ring[0][15:8]));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(dump_valid), 32'd0);
        chk("arst_busy", 32'(dump_busy), 32'd0);
        chk("arst_outs", 32'({fill, total_count, latest_digit, drop_flag}), 32'd0);
        chk("arst_rd", 32'({rd_hit, rd_digit, rd_score}), 32'd0);
        chk("arst_data", 32'({dump_last, dump_data}), 32'd0);
        dump_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ring.delete();
        m_total  = 0;
        m_latest = '0;
        @(negedge clk);
        run_dump(0, build_dump(), -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
